// File: rtl/game_flow_pkg.sv
// -----------------------------------------------------------------------------
// game_flow_pkg
// Shared types and defaults for the PACMAN game-flow controller.
//   game_state_t      : top-level game phase
//   DEF_LIVES         : default lives at game start (legal 1..7)
//   DEF_DEATH_FRAMES  : default freeze length after a hit, in frames
//   DEF_MSG_FRAMES    : default minimum win/lose screen hold, in frames
//   maxInt()          : larger of two integers, used to size the frame counter
// -----------------------------------------------------------------------------
package game_flow_pkg;

    typedef enum logic [2:0] {
        START = 3'd0,
        PLAY  = 3'd1,
        DEATH = 3'd2,
        WON   = 3'd3,
        LOST  = 3'd4
    } game_state_t;

    localparam int DEF_LIVES        = 3;
    localparam int DEF_DEATH_FRAMES = 120;
    localparam int DEF_MSG_FRAMES   = 180;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_flow_fsm_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Saturating counter of startOfFrame pulses. Shared by the death pause and the
// win/lose message hold; the owner selects the limit and clears it on entry.
//   clk, reset    : clock, asynchronous active-high reset
//   clear         : zero the count (takes priority over a coincident pulse)
//   startOfFrame  : one-cycle pulse per video frame
//   limit         : saturation value
//   done          : count has reached limit (decoded from the count register)
// -----------------------------------------------------------------------------
module frame_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             startOfFrame,
    input  logic [WIDTH-1:0] limit,
    output logic             done
);

    logic [WIDTH-1:0] count_r;

    // Frame count register: clear wins, otherwise count up to limit and hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (startOfFrame && (count_r < limit)) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r >= limit);

endmodule

// File: rtl/game_flow_fsm.sv
// -----------------------------------------------------------------------------
// game_flow_fsm
// Top-level game-state controller for the PACMAN display path.
//   clk           : VGA pixel clock
//   reset         : asynchronous active-high reset
//   startOfFrame  : one-cycle pulse per video frame
//   startKey      : start key level (synchronous to clk)
//   allEaten      : pulse when the last pellet is eaten
//   pacmanHit     : pulse on a ghost collision
//   pressToStart  : start screen active
//   gameWon       : win screen active
//   gameLost      : lose screen active
//   gamePlaying   : actors may move
//   freeze        : actors held still during the death pause
//   levelReset    : one-cycle pulse to reload maze / actors
//   livesLeft     : remaining lives
// All outputs come from registers; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module game_flow_fsm
    import game_flow_pkg::*;
#(
    parameter int LIVES        = DEF_LIVES,
    parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
    parameter int MSG_FRAMES   = DEF_MSG_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       allEaten,
    input  logic       pacmanHit,
    output logic       pressToStart,
    output logic       gameWon,
    output logic       gameLost,
    output logic       gamePlaying,
    output logic       freeze,
    output logic       levelReset,
    output logic [2:0] livesLeft
);

    localparam int                CNT_W      = $clog2(maxInt(DEATH_FRAMES, MSG_FRAMES) + 1);
    localparam logic [CNT_W-1:0]  DEATH_LIM  = CNT_W'(DEATH_FRAMES);
    localparam logic [CNT_W-1:0]  MSG_LIM    = CNT_W'(MSG_FRAMES);
    localparam logic [2:0]        LIVES_INIT = 3'(LIVES);

    game_state_t      state_r;
    game_state_t      nextState_s;
    logic             startKeyD_r;
    logic             keyRise_s;
    logic [2:0]       lives_r;
    logic             levelReset_r;
    logic             timerClear_s;
    logic [CNT_W-1:0] timerLimit_s;
    logic             timerDone_s;

    // startKeyD_r resets high so a key held through reset is not a press.
    assign keyRise_s    = startKey & ~startKeyD_r;
    assign timerLimit_s = (state_r == DEATH) ? DEATH_LIM : MSG_LIM;

    frame_timer #(
        .WIDTH (CNT_W)
    ) uFrameTimer (
        .clk          (clk),
        .reset        (reset),
        .clear        (timerClear_s),
        .startOfFrame (startOfFrame),
        .limit        (timerLimit_s),
        .done         (timerDone_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= START;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic and frame-timer clear on entry to a timed state.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            START: begin
                if (keyRise_s) nextState_s = PLAY;
                else           nextState_s = START;
            end
            PLAY: begin
                // allEaten outranks a coincident hit.
                if (allEaten)                          nextState_s = WON;
                else if (pacmanHit && lives_r <= 3'd1) nextState_s = LOST;
                else if (pacmanHit)                    nextState_s = DEATH;
                else                                   nextState_s = PLAY;
            end
            DEATH: begin
                if (timerDone_s) nextState_s = PLAY;
                else             nextState_s = DEATH;
            end
            WON, LOST: begin
                if (timerDone_s && keyRise_s) nextState_s = START;
                else                          nextState_s = state_r;
            end
            default: nextState_s = START;
        endcase

        timerClear_s = 1'b0;
        if ((nextState_s != state_r) &&
            (nextState_s == DEATH || nextState_s == WON || nextState_s == LOST)) begin
            timerClear_s = 1'b1;
        end else begin
            timerClear_s = 1'b0;
        end
    end

    // Key-edge history, lives counter and levelReset pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            startKeyD_r  <= 1'b1;
            lives_r      <= LIVES_INIT;
            levelReset_r <= 1'b0;
        end else begin
            startKeyD_r  <= startKey;
            levelReset_r <= (nextState_s == PLAY) &&
                            (state_r == START || state_r == DEATH);
            if (state_r == START && nextState_s == PLAY) begin
                lives_r <= LIVES_INIT;
            end else if (state_r == PLAY &&
                         (nextState_s == DEATH || nextState_s == LOST)) begin
                lives_r <= lives_r - 3'd1;
            end else begin
                lives_r <= lives_r;
            end
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        pressToStart = 1'b0;
        gameWon      = 1'b0;
        gameLost     = 1'b0;
        gamePlaying  = 1'b0;
        freeze       = 1'b0;
        case (state_r)
            START:   pressToStart = 1'b1;
            PLAY:    gamePlaying  = 1'b1;
            DEATH:   freeze       = 1'b1;
            WON:     gameWon      = 1'b1;
            LOST:    gameLost     = 1'b1;
            default: pressToStart = 1'b0;
        endcase
    end

    assign levelReset = levelReset_r;
    assign livesLeft  = lives_r;

endmodule

// File: tb/tb_game_flow_fsm.sv
// -----------------------------------------------------------------------------
// tb_game_flow_fsm
// Scoreboard bench: stimulus pushes {expected cycle, expected output vector}
// for every output change it causes; the monitor pops an entry each time the
// output vector changes and compares value and cycle.
// Vector layout: {pressToStart, gameWon, gameLost, gamePlaying, freeze,
//                 levelReset, livesLeft[2:0]}
// -----------------------------------------------------------------------------
module tb_game_flow_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       startKey = 1'b1;
    logic       allEaten = 1'b0;
    logic       pacmanHit = 1'b0;
    logic       pressToStart, gameWon, gameLost, gamePlaying, freeze, levelReset;
    logic [2:0] livesLeft;

    game_flow_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .startKey     (startKey),
        .allEaten     (allEaten),
        .pacmanHit    (pacmanHit),
        .pressToStart (pressToStart),
        .gameWon      (gameWon),
        .gameLost     (gameLost),
        .gamePlaying  (gamePlaying),
        .freeze       (freeze),
        .levelReset   (levelReset),
        .livesLeft    (livesLeft)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [8:0] vec;
        string      name;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         nVec = 0;
    int         nMis = 0;
    bit         monOn = 1'b0;
    logic [8:0] prevV;
    logic [8:0] outV;

    assign outV = {pressToStart, gameWon, gameLost, gamePlaying, freeze,
                   levelReset, livesLeft};

    function automatic logic [8:0] mk(bit pts, bit won, bit lost, bit play,
                                      bit frz, bit lr, logic [2:0] lives);
        return {pts, won, lost, play, frz, lr, lives};
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every output change must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (monOn && outV !== prevV) begin
            nVec = nVec + 1;
            if (q.size() == 0) begin
                nMis = nMis + 1;
                $display("FAIL unexpected_change: cycle %0d got %b (no change expected)", cyc, outV);
            end else begin
                e = q.pop_front();
                if (outV !== e.vec || cyc != e.cyc) begin
                    nMis = nMis + 1;
                    $display("FAIL %s: got %b at cycle %0d, want %b at cycle %0d",
                             e.name, outV, cyc, e.vec, e.cyc);
                end
            end
            prevV = outV;
        end
    end

    task automatic push(input int c, input logic [8:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.vec = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
        nVec = nVec + 1;
        if (got !== want) begin
            nMis = nMis + 1;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    // One frame: a single-cycle startOfFrame then three idle cycles.
    task automatic frame();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One-cycle key press followed by a release cycle.
    task automatic press();
        startKey = 1'b1;
        @(negedge clk);
        startKey = 1'b0;
        @(negedge clk);
    endtask

    // Hit pulse, optionally coincident with a frame pulse.
    task automatic hit(input logic [8:0] v, input bit withSof, input string nm);
        pacmanHit    = 1'b1;
        startOfFrame = withSof;
        push(cyc + 1, v, nm);
        @(negedge clk);
        pacmanHit    = 1'b0;
        startOfFrame = 1'b0;
        @(negedge clk);
    endtask

    // Full death pause: after frame 120 is counted, PLAY with a levelReset pulse.
    task automatic pause(input logic [2:0] lives, input bit inject);
        for (int i = 1; i <= 120; i++) begin
            if (i == 120) begin
                push(cyc + 2, mk(0, 0, 0, 1, 0, 1, lives), "death_exit");
                push(cyc + 3, mk(0, 0, 0, 1, 0, 0, lives), "death_lr_drop");
            end
            frame();
            if (inject && i == 30) begin
                allEaten  = 1'b1;
                pacmanHit = 1'b1;
                @(negedge clk);
                allEaten  = 1'b0;
                pacmanHit = 1'b0;
            end
        end
    endtask

    // Message hold: early key at earlyAt frames ignored, key after 180 returns to START.
    task automatic hold(input int earlyAt, input logic [2:0] lives);
        for (int i = 1; i <= 180; i++) begin
            frame();
            if (i == earlyAt) press();
        end
        push(cyc + 1, mk(1, 0, 0, 0, 0, 0, lives), "msg_to_start");
        press();
    endtask

    task automatic startGame();
        push(cyc + 1, mk(0, 0, 0, 1, 0, 1, 3'd3), "start_play");
        push(cyc + 2, mk(0, 0, 0, 1, 0, 0, 3'd3), "start_lr_drop");
        press();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with startKey held high.
        @(negedge clk);
        chk("reset_state", outV, mk(1, 0, 0, 0, 0, 0, 3'd3));
        reset = 1'b0;
        prevV = outV;
        monOn = 1'b1;
        // Key still held after release: no start expected.
        repeat (5) @(negedge clk);
        startKey = 1'b0;
        repeat (2) @(negedge clk);

        // Game 1: two hits with pauses, then simultaneous allEaten/hit -> WON.
        startGame();
        repeat (3) @(negedge clk);
        hit(mk(0, 0, 0, 0, 1, 0, 3'd2), 1'b0, "hit1_death");
        pause(3'd2, 1'b1);
        repeat (2) @(negedge clk);
        hit(mk(0, 0, 0, 0, 1, 0, 3'd1), 1'b1, "hit2_death_sof");
        pause(3'd1, 1'b0);
        repeat (2) @(negedge clk);
        allEaten  = 1'b1;
        pacmanHit = 1'b1;
        push(cyc + 1, mk(0, 1, 0, 0, 0, 0, 3'd1), "win_over_hit");
        @(negedge clk);
        allEaten  = 1'b0;
        pacmanHit = 1'b0;
        hold(100, 3'd1);

        // Game 2: three hits -> LOST; key at frame 179 ignored.
        repeat (2) @(negedge clk);
        startGame();
        hit(mk(0, 0, 0, 0, 1, 0, 3'd2), 1'b0, "g2_hit1");
        pause(3'd2, 1'b0);
        hit(mk(0, 0, 0, 0, 1, 0, 3'd1), 1'b0, "g2_hit2");
        pause(3'd1, 1'b0);
        hit(mk(0, 0, 1, 0, 0, 0, 3'd0), 1'b0, "g2_hit3_lost");
        hold(179, 3'd0);

        // Game 3: reset during the death pause at frame 60.
        repeat (2) @(negedge clk);
        startGame();
        hit(mk(0, 0, 0, 0, 1, 0, 3'd2), 1'b0, "g3_hit1");
        repeat (60) frame();
        #1 reset = 1'b1;
        #1 chk("async_reset_now", outV, mk(1, 0, 0, 0, 0, 0, 3'd3));
        push(cyc + 1, mk(1, 0, 0, 0, 0, 0, 3'd3), "async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nVec = nVec + 1;
            nMis = nMis + 1;
            $display("FAIL %s: never seen, want %b at cycle %0d", e.name, e.vec, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
